vedic_mult_seq: RTL
===================

# vedic_mult_seq

Parametrised, multi-cycle Urdhva-Tiryakbhyam (Vedic) multiplier with valid/ready handshakes and selectable signed or unsigned mode. It is the sequential successor to the combinational `mult_64bit` tree. The datapath is reused: only one column of DIGIT×DIGIT partial products is evaluated per cycle, which trades latency for area. It sits between the operand source and the result consumer on the single core clock.

## Interface
- WIDTH, 64: operand width in bits. Must be a multiple of DIGIT.
- DIGIT, 16: digit width in bits. Power of two, ≥2. N = WIDTH/DIGIT must be ≥2.
- clk  input  1  core clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept operands. High only in IDLE with rst low.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- signed_mode  input  1  1 = two's-complement operands and result; 0 = unsigned.
- out_valid  output  1  c holds a completed product.
- out_ready  input  1  consumer accepts c.
- c  output  2*WIDTH  product.
- busy  output  1  high in CALC or DONE.

## Operation
- States: IDLE, CALC, DONE. Reset forces IDLE, column counter col=0, accumulator=0, c=0, out_valid=0, busy=0.
- **IDLE:**
  - Accept when in_valid && in_ready.
  - Register the magnitudes of a and b. In signed mode, an operand with MSB set is negated. −2^(WIDTH−1) maps to magnitude 2^(WIDTH−1), which fits in WIDTH bits unsigned.
  - Register neg = signed_mode & (a[MSB] ^ b[MSB]). In unsigned mode neg=0.
  - Clear the accumulator, set col=0, go to CALC.
- **CALC:**
  - Split the magnitudes into digits A_i, B_j, where i,j ∈ 0..N−1 and digit 0 is least significant.
  - Each cycle, form column sum S = Σ A_i·B_j over all i+j=col. S is 2*DIGIT+clog2(N) bits wide.
  - Add S<<(col*DIGIT) into the 2*WIDTH-bit accumulator.
  - When col==2N−2, perform the final add, load c with the accumulator (two's-complement negated if neg), set out_valid, and go to DONE. Otherwise increment col.
  - Accumulator arithmetic never overflows 2*WIDTH bits. Negating zero yields zero.
- **DONE:**
  - c and out_valid hold stable until out_ready.
  - On out_valid && out_ready: clear out_valid, go to IDLE. c retains its value.
- in_valid is ignored outside IDLE. a, b and signed_mode may change freely after acceptance.
- Reset asserted in any state aborts the operation immediately. Outputs return to reset values asynchronously and no result is produced.

## Timing
- Latency: operands accepted at edge T produce out_valid=1 and a valid c after edge T+2N−1. Defaults give N=4, so latency is 7 cycles.
- Minimum initiation interval is 2N+1 cycles: accept, 2N−1 CALC edges, one DONE handshake edge, then the next accept.
- in_ready rises the cycle after the DONE handshake edge.
- out_valid stays high through any number of out_ready=0 cycles. c does not change while out_valid=1.
- in_ready and busy are combinational from state and rst. All other outputs are registered.
- Reset deassertion: in_ready is high in the first cycle after rst falls. An accept is possible on the first rising edge after deassertion.

## Test plan
- **Unsigned, default params:** a=16743343434, b=2, signed_mode=0. Expect c=33486686868, with out_valid rising exactly 7 cycles after the accept edge and busy high throughout.
- **Unsigned corner:** a=b=2^64−1. Expect c=0xFFFFFFFFFFFFFFFE_0000000000000001. Then a=0, b=0xDEADBEEF: expect c=0.
- **Signed:**
  - a=−3, b=5: expect c=0xFFFF…FFF1 (−15).
  - a=b=−1: expect c=1.
  - a=b=−2^63: expect c=2^126 (0x4000…0).
  - a=−2^63, b=1: expect c=0xFFFF…FFFF_8000…0000.
- **Backpressure:**
  - Hold out_ready=0 for 10 cycles after out_valid. c and out_valid must be stable, and in_ready must stay 0 while in_valid=1 with changing a/b.
  - Raise out_ready. in_ready must be 1 on the following cycle, and the next product must be unaffected by the ignored inputs.
- **Reset mid-CALC:** assert rst at col=3. out_valid, c, busy and col must be 0 immediately and in_ready must be 0 during reset. After release, a fresh 7×6=42 must complete normally.
- **Param sweep:** WIDTH=8, DIGIT=2 (N=4) and WIDTH=32, DIGIT=16 (N=2), checking latency 2N−1. Compare 1000 random signed and unsigned products against a behavioural `*` reference, with random out_ready stalls.

Source files
------------

// File: rtl/vedic_mult_seq.sv
// ---------------------------------------------------------------------------
// vedic_mult_seq
//
// This is a multi-cycle Urdhva-Tiryakbhyam (vertical and crosswise)
// multiplier. The operands are split into N = WIDTH/DIGIT digits. Each cycle
// evaluates one column of the crosswise product, which is the sum of every
// A_i*B_j with i+j == col. That column sum is then added into a 2*WIDTH-bit
// accumulator at offset col*DIGIT. Only N DIGIT x DIGIT multipliers exist,
// and they are reused across all 2N-1 columns.
//
// Signed mode multiplies the operand magnitudes and negates the result when
// the operand signs differ.
//
// Ports
//   clk          core clock, rising edge
//   rst          asynchronous, active-high reset
//   in_valid     a, b and signed_mode are valid
//   in_ready     operands can be accepted (IDLE and not in reset)
//   a, b         WIDTH-bit operands
//   signed_mode  1 = two's-complement operands and result, 0 = unsigned
//   out_valid    c holds a completed product
//   out_ready    consumer accepts c
//   c            2*WIDTH-bit product
//   busy         a product is in flight or waiting to be taken (CALC/DONE)
//
// Latency: an accept at edge T gives out_valid after edge T+2N-1.
// ---------------------------------------------------------------------------
module vedic_mult_seq #(
  parameter int WIDTH = 64,
  parameter int DIGIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   c,
  output logic                 busy
);

  localparam int N     = WIDTH / DIGIT;
  localparam int COL_W = $clog2(2 * N - 1);
  localparam int SUM_W = 2 * DIGIT + $clog2(N);
  localparam int ACC_W = 2 * WIDTH;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(2 * N - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t             state;
  logic [COL_W-1:0]   col;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               neg;
  logic [ACC_W-1:0]   acc;

  logic [DIGIT-1:0]   db;
  logic [SUM_W-1:0]   col_sum;
  logic [ACC_W-1:0]   acc_next;
  logic [ACC_W-1:0]   result;

  assign in_ready = (state == S_IDLE) && !rst;
  assign busy     = (state != S_IDLE);

  // Each A_i is multiplied by the single B digit that lands in the current
  // column (j = col - i). When no such B digit exists, a zero is selected,
  // so only N multipliers are built, not N*N.
  // NOTE: every variable assigned in this block gets a default value before
  // any conditional assignment. Without that, synthesis would infer latches.
  always_comb begin
    col_sum = '0;
    db      = '0;
    for (int i = 0; i < N; i++) begin
      db = '0;
      for (int j = 0; j < N; j++) begin
        if (i + j == int'(col)) db = mag_b[j*DIGIT +: DIGIT];
      end
      col_sum = col_sum + SUM_W'({{DIGIT{1'b0}}, mag_a[i*DIGIT +: DIGIT]} *
                                 {{DIGIT{1'b0}}, db});
    end
    acc_next = acc + (ACC_W'(col_sum) << (int'(col) * DIGIT));
    result   = neg ? (~acc_next + ACC_W'(1)) : acc_next;
  end

  // NOTE: all state below uses non-blocking assignments, so every register
  // samples the values that existed before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the datapath registers are reset along with the control
      // registers. An aborted operation then leaves no stale magnitudes or
      // partial sums behind.
      state     <= S_IDLE;
      col       <= '0;
      mag_a     <= '0;
      mag_b     <= '0;
      neg       <= 1'b0;
      acc       <= '0;
      c         <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            // The most negative value negates to 2^(WIDTH-1). That value
            // still fits as an unsigned WIDTH-bit magnitude.
            mag_a <= (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
            mag_b <= (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
            neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc   <= '0;
            col   <= '0;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          acc <= acc_next;
          if (col == LAST_COL) begin
            c         <= result;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            col <= col + COL_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
